// File: rtl/stage_execute_muldiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
// Decode drives md_op with the MD_OP_* encodings below.
package stage_execute_muldiv_pkg;

    localparam int unsigned MD_OP_LEN = 3;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [MD_OP_LEN-1:0] {
        MD_OP_NONE  = 3'd0,
        MD_OP_MULT  = 3'd1,
        MD_OP_MULTU = 3'd2,
        MD_OP_DIV   = 3'd3,
        MD_OP_DIVU  = 3'd4,
        MD_OP_MTHI  = 3'd5,
        MD_OP_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // HI/LO pair carried from the accept cycle to the commit edge
    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } hilo_t;

endpackage

// File: rtl/stage_execute_muldiv.sv
// Multi-cycle multiply/divide unit holding architectural HI/LO.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   start, md_op       issue strobe and operation (MD_OP_*)
//   src0, src1         rs (dividend/multiplicand), rt (divisor/multiplier)
//   busy               operation in flight (registered)
//   hi, lo             HI/LO registers (registered)
// The result is computed combinationally in the accept cycle and held
// internally; the RUN counter only models the architectural latency.
module stage_execute_muldiv
    import stage_execute_muldiv_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [MD_OP_LEN-1:0] md_op,
    input  logic [DATA_W-1:0]    src0,
    input  logic [DATA_W-1:0]    src1,
    output logic                 busy,
    output logic [DATA_W-1:0]    hi,
    output logic [DATA_W-1:0]    lo
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    hilo_t              res_q, res_d;
    logic               dz_q, dz_d;
    logic [DATA_W-1:0]  hi_d, lo_d;

    md_op_e             op;
    logic [2*DATA_W-1:0] prod_s, prod_u;
    logic               div_zero, div_ovf;
    logic [DATA_W-1:0]  dvs_s, dvs_u;
    logic signed [DATA_W-1:0] q_s, r_s;
    logic [DATA_W-1:0]  q_u, r_u;

    assign op = md_op_e'(md_op);

    // Low 64 bits of a product of sign-extended operands equal the signed product
    assign prod_s = {{DATA_W{src0[DATA_W-1]}}, src0} * {{DATA_W{src1[DATA_W-1]}}, src1};
    assign prod_u = {{DATA_W{1'b0}}, src0} * {{DATA_W{1'b0}}, src1};

    // Divisor forced to 1 on zero and on INT_MIN/-1 so the divider never faults;
    // those two cases are resolved explicitly below.
    assign div_zero = (src1 == '0);
    assign div_ovf  = (src0 == {1'b1, {(DATA_W-1){1'b0}}}) && (src1 == '1);
    assign dvs_s    = (div_zero || div_ovf) ? DATA_W'(1) : src1;
    assign dvs_u    = div_zero ? DATA_W'(1) : src1;
    assign q_s      = $signed(src0) / $signed(dvs_s);
    assign r_s      = $signed(src0) % $signed(dvs_s);
    assign q_u      = src0 / dvs_u;
    assign r_u      = src0 % dvs_u;

    // State, counter and HI/LO registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            dz_q    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            dz_q    <= dz_d;
            hi      <= hi_d;
            lo      <= lo_d;
        end
    end

    assign busy = (state_q == ST_RUN);

    // Accept in IDLE, count down and commit in RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        dz_d    = dz_q;
        hi_d    = hi;
        lo_d    = lo;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MD_OP_MULT: begin
                            res_d   = prod_s;
                            dz_d    = 1'b0;
                            cnt_d   = CNT_W'(MULT_CYCLES - 1);
                            state_d = ST_RUN;
                        end
                        MD_OP_MULTU: begin
                            res_d   = prod_u;
                            dz_d    = 1'b0;
                            cnt_d   = CNT_W'(MULT_CYCLES - 1);
                            state_d = ST_RUN;
                        end
                        MD_OP_DIV: begin
                            res_d.hi = div_ovf ? '0 : DATA_W'(r_s);
                            res_d.lo = div_ovf ? src0 : DATA_W'(q_s);
                            dz_d     = div_zero;
                            cnt_d    = CNT_W'(DIV_CYCLES - 1);
                            state_d  = ST_RUN;
                        end
                        MD_OP_DIVU: begin
                            res_d.hi = r_u;
                            res_d.lo = q_u;
                            dz_d     = div_zero;
                            cnt_d    = CNT_W'(DIV_CYCLES - 1);
                            state_d  = ST_RUN;
                        end
                        MD_OP_MTHI: hi_d = src0;
                        MD_OP_MTLO: lo_d = src0;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) begin
                    if (!dz_q) begin
                        hi_d = res_q.hi;
                        lo_d = res_q.lo;
                    end
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
